// File: rtl/cascaded_tick_gen.sv
// Cascaded clock-enable divider chain: each stage divides the carry of the stage below by (limit+1).
// Limits are written to a pending register and only take effect at that stage's wrap or on load.
module cascaded_tick_gen #(
    parameter int NSTAGE        = 3,
    parameter int W             = 5,
    parameter int DEFAULT_LIMIT = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  load,
    input  logic                  tick_in,
    input  logic                  limit_wr,
    input  logic [2:0]            limit_sel,
    input  logic [W-1:0]          limit_data,
    output logic [NSTAGE-1:0]     tick_out,
    output logic [NSTAGE*W-1:0]   count_flat
);

    localparam logic [W-1:0] LIM_RST = W'(DEFAULT_LIMIT);

    logic [W-1:0]      r_cnt  [NSTAGE];
    logic [W-1:0]      r_lim  [NSTAGE];
    logic [W-1:0]      r_pend [NSTAGE];
    logic [NSTAGE-1:0] r_tick;

    logic [NSTAGE-1:0] w_carry;
    logic [NSTAGE-1:0] w_at_lim;
    logic [NSTAGE-1:0] w_wrap;
    logic [NSTAGE-1:0] w_wr_hit;

    assign w_carry[0] = en & tick_in & ~load;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k > 0) begin : g_chain
            assign w_carry[k] = w_wrap[k-1];
        end

        assign w_at_lim[k] = (r_cnt[k] == r_lim[k]);
        assign w_wrap[k]   = w_carry[k] & w_at_lim[k];
        // Out-of-range selects never match because k < NSTAGE <= 8.
        assign w_wr_hit[k] = limit_wr && (limit_sel == 3'(k));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt[k]  <= '0;
                r_lim[k]  <= LIM_RST;
                r_tick[k] <= 1'b0;
            end else if (load) begin
                r_cnt[k]  <= '0;
                r_lim[k]  <= r_pend[k];
                r_tick[k] <= 1'b0;
            end else begin
                r_tick[k] <= w_wrap[k];
                if (w_wrap[k]) begin
                    r_cnt[k] <= '0;
                    r_lim[k] <= r_pend[k];
                end else if (w_carry[k]) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end

        // A write coinciding with a wrap or load lands here one cycle too late for that
        // apply, so L picks up the old pending value and the new one waits for the next wrap.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pend[k] <= LIM_RST;
            end else if (w_wr_hit[k]) begin
                r_pend[k] <= limit_data;
            end
        end

        assign count_flat[k*W +: W] = r_cnt[k];
    end

    assign tick_out = r_tick;

endmodule

// File: tb/tb_cascaded_tick_gen.sv
// Directed self-checking bench for cascaded_tick_gen (NSTAGE=3, W=5, DEFAULT_LIMIT=7).
// Inputs change and outputs are sampled on the falling edge; the DUT updates on the rising edge.
module tb_cascaded_tick_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        load;
    logic        tick_in;
    logic        limit_wr;
    logic [2:0]  limit_sel;
    logic [4:0]  limit_data;
    logic [2:0]  tick_out;
    logic [14:0] count_flat;

    int checks   = 0;
    int failures = 0;

    cascaded_tick_gen #(.NSTAGE(3), .W(5), .DEFAULT_LIMIT(7)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .load       (load),
        .tick_in    (tick_in),
        .limit_wr   (limit_wr),
        .limit_sel  (limit_sel),
        .limit_data (limit_data),
        .tick_out   (tick_out),
        .count_flat (count_flat)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; load = 1'b0; tick_in = 1'b0;
        limit_wr = 1'b0; limit_sel = 3'd0; limit_data = 5'd0;
        step(); step();
        checks++;
        if (tick_out !== 3'b000) begin
            failures++; $display("FAIL reset_tick got=%b exp=000", tick_out);
        end
        checks++;
        if (count_flat !== 15'd0) begin
            failures++; $display("FAIL reset_count got=%h exp=0000", count_flat);
        end
    endtask

    task automatic test_defaults();
        int first [3];
        int cnt0;
        first = '{-1, -1, -1};
        cnt0  = 0;
        reset_n = 1'b1; en = 1'b1; tick_in = 1'b1;
        for (int n = 1; n <= 520; n++) begin
            step();
            for (int k = 0; k < 3; k++)
                if (tick_out[k] && first[k] < 0) first[k] = n;
            if (tick_out[0]) cnt0++;
        end
        checks++;
        if (first[0] !== 8) begin
            failures++; $display("FAIL dflt_first_tick0 got=%0d exp=8", first[0]);
        end
        checks++;
        if (first[1] !== 64) begin
            failures++; $display("FAIL dflt_first_tick1 got=%0d exp=64", first[1]);
        end
        checks++;
        if (first[2] !== 512) begin
            failures++; $display("FAIL dflt_first_tick2 got=%0d exp=512", first[2]);
        end
        checks++;
        if (cnt0 !== 65) begin
            failures++; $display("FAIL dflt_tick0_count got=%0d exp=65", cnt0);
        end
        checks++;
        if (count_flat !== 15'h0020) begin
            failures++; $display("FAIL dflt_count_flat got=%h exp=0020", count_flat);
        end
    endtask

    task automatic test_slow_tick_in();
        int last0, last1, cnt0, cnt1;
        logic prev0, prev1;
        last0 = -1; last1 = -1; cnt0 = 0; cnt1 = 0; prev0 = 1'b0; prev1 = 1'b0;
        load = 1'b1; en = 1'b1; tick_in = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick_in = (i % 4 == 0);
            step();
            if (tick_out[0]) begin
                cnt0++;
                checks++;
                if (prev0) begin
                    failures++; $display("FAIL slow_tick0_width at=%0d prev=%b exp=0", i, prev0);
                end
                if (last0 >= 0) begin
                    checks++;
                    if (i - last0 != 32) begin
                        failures++; $display("FAIL slow_tick0_period got=%0d exp=32", i - last0);
                    end
                end
                last0 = i;
            end
            if (tick_out[1]) begin
                cnt1++;
                checks++;
                if (prev1) begin
                    failures++; $display("FAIL slow_tick1_width at=%0d prev=%b exp=0", i, prev1);
                end
                if (last1 >= 0) begin
                    checks++;
                    if (i - last1 != 256) begin
                        failures++; $display("FAIL slow_tick1_period got=%0d exp=256", i - last1);
                    end
                end
                last1 = i;
            end
            prev0 = tick_out[0];
            prev1 = tick_out[1];
        end
        tick_in = 1'b1;
        checks++;
        if (cnt0 !== 18) begin
            failures++; $display("FAIL slow_tick0_count got=%0d exp=18", cnt0);
        end
        checks++;
        if (cnt1 !== 2) begin
            failures++; $display("FAIL slow_tick1_count got=%0d exp=2", cnt1);
        end
    endtask

    task automatic test_limit_update();
        int first0, first1, last0, last1, cnt0;
        first0 = -1; first1 = -1; last0 = -1; last1 = -1; cnt0 = 0;
        load = 1'b1; en = 1'b1; tick_in = 1'b1; limit_wr = 1'b0;
        step();
        load = 1'b0;
        for (int n = 1; n <= 110; n++) begin
            if (n == 3) begin
                limit_wr = 1'b1; limit_sel = 3'd0; limit_data = 5'd3;
            end else begin
                limit_wr = 1'b0;
            end
            step();
            if (n == 2) begin
                checks++;
                if (count_flat[4:0] !== 5'd2) begin
                    failures++; $display("FAIL upd_c0_before_write got=%0d exp=2", count_flat[4:0]);
                end
            end
            if (tick_out[0]) begin
                cnt0++;
                if (first0 < 0) first0 = n;
                else begin
                    checks++;
                    if (n - last0 != 4) begin
                        failures++; $display("FAIL upd_tick0_period got=%0d exp=4", n - last0);
                    end
                end
                last0 = n;
            end
            if (tick_out[1]) begin
                if (first1 < 0) first1 = n;
                else begin
                    checks++;
                    if (n - last1 != 32) begin
                        failures++; $display("FAIL upd_tick1_period got=%0d exp=32", n - last1);
                    end
                end
                last1 = n;
            end
        end
        checks++;
        if (first0 !== 8) begin
            failures++; $display("FAIL upd_first_tick0 got=%0d exp=8", first0);
        end
        checks++;
        if (first1 !== 36) begin
            failures++; $display("FAIL upd_first_tick1 got=%0d exp=36", first1);
        end
        checks++;
        if (cnt0 !== 26) begin
            failures++; $display("FAIL upd_tick0_count got=%0d exp=26", cnt0);
        end
    endtask

    task automatic test_load();
        int first0, first1;
        first0 = -1; first1 = -1;
        en = 1'b0; limit_wr = 1'b1; limit_sel = 3'd0; limit_data = 5'd7;
        step();
        limit_wr = 1'b0; load = 1'b1; en = 1'b1; tick_in = 1'b1;
        step();
        load = 1'b0;
        repeat (345) step();
        checks++;
        if (count_flat !== 15'd5217) begin
            failures++; $display("FAIL load_pre_count got=%0d exp=5217", count_flat);
        end
        en = 1'b0; limit_wr = 1'b1; limit_sel = 3'd1; limit_data = 5'd2;
        step();
        checks++;
        if (count_flat !== 15'd5217 || tick_out !== 3'b000) begin
            failures++; $display("FAIL en_low_hold got=%0d/%b exp=5217/000", count_flat, tick_out);
        end
        limit_wr = 1'b0; load = 1'b1; en = 1'b1; tick_in = 1'b1;
        step();
        checks++;
        if (count_flat !== 15'd0) begin
            failures++; $display("FAIL load_clear got=%h exp=0000", count_flat);
        end
        checks++;
        if (tick_out !== 3'b000) begin
            failures++; $display("FAIL load_no_tick got=%b exp=000", tick_out);
        end
        load = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            step();
            if (tick_out[0] && first0 < 0) first0 = n;
            if (tick_out[1] && first1 < 0) first1 = n;
        end
        checks++;
        if (first0 !== 8) begin
            failures++; $display("FAIL load_first_tick0 got=%0d exp=8", first0);
        end
        checks++;
        if (first1 !== 24) begin
            failures++; $display("FAIL load_applied_limit1 got=%0d exp=24", first1);
        end
        checks++;
        if (tick_out !== 3'b011) begin
            failures++; $display("FAIL load_tick_at24 got=%b exp=011", tick_out);
        end
    endtask

    task automatic test_async_reset();
        int first0, first1;
        first0 = -1; first1 = -1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (tick_out !== 3'b000) begin
            failures++; $display("FAIL async_rst_tick got=%b exp=000", tick_out);
        end
        checks++;
        if (count_flat !== 15'd0) begin
            failures++; $display("FAIL async_rst_count got=%h exp=0000", count_flat);
        end
        @(negedge clk);
        reset_n = 1'b1; en = 1'b1; tick_in = 1'b1; load = 1'b0; limit_wr = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            step();
            if (tick_out[0] && first0 < 0) first0 = n;
            if (tick_out[1] && first1 < 0) first1 = n;
        end
        checks++;
        if (first0 !== 8) begin
            failures++; $display("FAIL rst_first_tick0 got=%0d exp=8", first0);
        end
        checks++;
        if (first1 !== 64) begin
            failures++; $display("FAIL rst_limit1_default got=%0d exp=64", first1);
        end
    endtask

    task automatic test_limit_zero_and_bad_sel();
        int diff, cnt1, first0;
        diff = 0; cnt1 = 0; first0 = -1;
        en = 1'b0; limit_wr = 1'b1; limit_sel = 3'd1; limit_data = 5'd0;
        step();
        limit_wr = 1'b0; load = 1'b1; en = 1'b1; tick_in = 1'b1;
        step();
        load = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (tick_out[1] !== tick_out[0]) diff++;
            if (tick_out[1]) cnt1++;
        end
        checks++;
        if (diff !== 0) begin
            failures++; $display("FAIL lim0_coincide mismatched_cycles=%0d exp=0", diff);
        end
        checks++;
        if (cnt1 !== 5) begin
            failures++; $display("FAIL lim0_tick1_count got=%0d exp=5", cnt1);
        end
        en = 1'b0; limit_wr = 1'b1; limit_sel = 3'd5; limit_data = 5'd1;
        step();
        checks++;
        if (count_flat !== 15'd5120) begin
            failures++; $display("FAIL badsel_hold got=%0d exp=5120", count_flat);
        end
        limit_wr = 1'b0; load = 1'b1; en = 1'b1; tick_in = 1'b1;
        step();
        load = 1'b0;
        diff = 0; cnt1 = 0;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (tick_out[0] && first0 < 0) first0 = n;
            if (tick_out[1] !== tick_out[0]) diff++;
            if (tick_out[1]) cnt1++;
        end
        checks++;
        if (first0 !== 8) begin
            failures++; $display("FAIL badsel_tick0 got=%0d exp=8", first0);
        end
        checks++;
        if (diff !== 0 || cnt1 !== 2) begin
            failures++; $display("FAIL badsel_tick1 mismatched=%0d cnt=%0d exp=0/2", diff, cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_slow_tick_in();
        test_limit_update();
        test_load();
        test_async_reset();
        test_limit_zero_and_bad_sel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
